truth_table_sweeper: RTL
========================

// Module: truth_table_sweeper
// PURPOSE
//  Exhaustively drives the 4-bit selector x of a combinational function block
//  through all 2**N_IN codes and samples its 1-bit result f.
//  Assembles the captured truth table and compares it with an expected vector.
//  Presents the result on a valid/ready handshake. Sits directly upstream
//  (x_out) and downstream (f_in) of the function block, as its built-in
//  self-check stage.
// PARAMETERS
//  N_IN    4  width of x; truth vector is TT_W = 2**N_IN bits
//  SETTLE  1  cycles x_out is held before f_in is sampled (>=1; <1 is illegal)
// PORTS
//  clk        in   1       single clock, all state on posedge
//  rst_n      in   1       asynchronous, active-low reset
//  start      in   1       begin a sweep; honoured only in IDLE
//  expected   in   TT_W    golden truth table, bit i = f(i); latched on start
//  f_in       in   1       output of the function block under sweep
//  x_out      out  N_IN    selector driven to the function block
//  busy       out  1       high in SWEEP and REPORT
//  out_valid  out  1       result valid (REPORT state)
//  out_ready  in   1       consumer accepts result when out_valid&&out_ready
//  truth      out  TT_W    captured table, bit i = f_in sampled at x_out==i
//  match      out  1       truth == expected latch
//  miscount   out  N_IN+1  popcount(truth ^ expected latch)
// BEHAVIOUR
//  Reset (async assert, sync deassert at the instantiating top):
//   state=IDLE; x_out=0; truth=0; match=0; miscount=0; busy=0; out_valid=0.
//  FSM, all outputs registered:
//   IDLE:   start=1 -> SWEEP. Latch expected, x_out=0, truth=0, settle=SETTLE-1.
//   SWEEP:  if settle!=0: settle--.
//           else: truth[x_out]<=f_in.
//            if x_out==TT_W-1 -> REPORT;
//            else x_out++, settle=SETTLE-1.
//   REPORT: out_valid=1; truth/match/miscount stable.
//           out_valid&&out_ready -> IDLE (x_out, truth hold their values).
//  Latency: the sweep occupies exactly TT_W*SETTLE cycles in SWEEP.
//   out_valid rises the cycle after the last sample.
//   With defaults: start at edge 0 -> out_valid high after edge 17.
//  match/miscount: computed combinationally from the final truth value and
//   registered on entry to REPORT, so they are valid together with out_valid.
//  Boundaries:
//   - start in SWEEP or REPORT is ignored; expected changes after start are
//     ignored.
//   - out_ready held low: stay in REPORT indefinitely with outputs frozen.
//   - start and out_ready both high in REPORT: return to IDLE only; a new
//     start must be asserted in IDLE (no back-to-back chaining).
//   - x_out never wraps: the sweep ends at TT_W-1.
//   - rst_n low mid-sweep or in REPORT: immediate return to reset values;
//     the partial table is discarded.
//   - f_in is X/unknown only while settle!=0; it must be stable at sample.
// STRUCTURE
//  Package tt_sweep_pkg:
//   - state enum {IDLE, SWEEP, REPORT}
//   - localparam N_IN_DEF=4, SETTLE_DEF=1
//   - function tt_w(n)=1<<n
//  Sub-module tt_popcount #(W): combinational ones-count of W bits producing
//   clog2(W)+1 bits; used for miscount.
//  One settle counter of width clog2(SETTLE)+1; the x_out register doubles as
//   the sweep index.
// TESTING
//  1. Function with minterms {0,1,4,5,6,12,14,15}, expected=16'hD073, start
//     -> truth=16'hD073, match=1, miscount=0, out_valid after 17 edges.
//  2. Same function, expected=16'hD072 -> truth=16'hD073, match=0, miscount=1.
//  3. SETTLE=3, f_in=x[0] with 2-cycle delay -> truth=16'hAAAA;
//     SWEEP lasts 48 cycles.
//  4. out_ready low for 10 cycles in REPORT -> out_valid, truth, match held;
//     a start pulse in that window is ignored; out_ready=1 -> IDLE next edge.
//  5. rst_n low when x_out==7 -> all outputs 0 immediately;
//     new start -> full clean sweep, correct result.
//  6. f_in tied 1, expected=16'h0000 -> truth=16'hFFFF, match=0, miscount=16.

Source files
------------

// File: rtl/truth_table_sweeper_pkg.sv
// tt_sweep_pkg: shared state encoding, default sizing and truth-table width helper for the sweeper
package tt_sweep_pkg;
  typedef enum logic [1:0] {IDLE, SWEEP, REPORT} state_e;
  localparam int N_IN_DEF = 4;
  localparam int SETTLE_DEF = 1;
  function automatic int tt_w(input int n);
    return 1 << n;
  endfunction
endpackage

// File: rtl/truth_table_sweeper_popcount.sv
// tt_popcount: combinational ones-count of v_i (W bits) onto cnt_o (clog2(W)+1 bits)
module tt_popcount
  import tt_sweep_pkg::*;
#(
  parameter int W = 16,
  localparam int CW = $clog2(W) + 1
) (
  input  logic [W-1:0]  v_i,
  output logic [CW-1:0] cnt_o
);
  always_comb begin
    cnt_o = '0;
    for (int i = 0; i < W; i++) cnt_o = cnt_o + CW'(v_i[i]);
  end
endmodule

// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: drives x_out over all codes, captures f_in into truth, compares with expected; ports clk/rst_n, start/expected in, f_in from the block, x_out to it, busy/out_valid/out_ready handshake, truth/match/miscount result
module truth_table_sweeper
  import tt_sweep_pkg::*;
#(
  parameter int N_IN = N_IN_DEF,
  parameter int SETTLE = SETTLE_DEF,
  localparam int TT_W = tt_w(N_IN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [TT_W-1:0] expected,
  input  logic            f_in,
  output logic [N_IN-1:0] x_out,
  output logic            busy,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [TT_W-1:0] truth,
  output logic            match,
  output logic [N_IN:0]   miscount
);
  localparam int SW = $clog2(SETTLE) + 1;
  localparam logic [SW-1:0] SETTLE_LD = SW'(SETTLE - 1);
  localparam logic [N_IN-1:0] LAST = N_IN'(TT_W - 1);
  state_e state_q, state_d;
  logic [N_IN-1:0] x_q, x_d;
  logic [TT_W-1:0] truth_q, truth_d, exp_q, exp_d, truth_s;
  logic [SW-1:0] settle_q, settle_d;
  logic busy_q, busy_d, valid_q, valid_d, match_q, match_d;
  logic [N_IN:0] mis_q, mis_d, pop;
  // table as it will look once the current sample lands, so match/miscount
  // can be registered on the same edge that enters REPORT
  always_comb begin
    truth_s = truth_q;
    truth_s[x_q] = f_in;
  end
  tt_popcount #(.W(TT_W)) u_pop (.v_i(truth_s ^ exp_q), .cnt_o(pop));
  always_comb begin
    state_d = state_q;
    x_d = x_q;
    truth_d = truth_q;
    exp_d = exp_q;
    settle_d = settle_q;
    busy_d = busy_q;
    valid_d = valid_q;
    match_d = match_q;
    mis_d = mis_q;
    unique case (state_q)
      IDLE: if (start) begin
        state_d = SWEEP;
        exp_d = expected;
        x_d = '0;
        truth_d = '0;
        settle_d = SETTLE_LD;
        busy_d = 1'b1;
      end
      SWEEP: if (settle_q != '0) begin
        settle_d = settle_q - 1'b1;
      end else begin
        truth_d = truth_s;
        if (x_q == LAST) begin
          state_d = REPORT;
          valid_d = 1'b1;
          match_d = truth_s == exp_q;
          mis_d = pop;
        end else begin
          x_d = x_q + 1'b1;
          settle_d = SETTLE_LD;
        end
      end
      REPORT: if (out_ready) begin
        state_d = IDLE;
        valid_d = 1'b0;
        busy_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x_q <= '0;
      truth_q <= '0;
      exp_q <= '0;
      settle_q <= '0;
      busy_q <= 1'b0;
      valid_q <= 1'b0;
      match_q <= 1'b0;
      mis_q <= '0;
    end else begin
      state_q <= state_d;
      x_q <= x_d;
      truth_q <= truth_d;
      exp_q <= exp_d;
      settle_q <= settle_d;
      busy_q <= busy_d;
      valid_q <= valid_d;
      match_q <= match_d;
      mis_q <= mis_d;
    end
  end
  assign x_out = x_q;
  assign truth = truth_q;
  assign busy = busy_q;
  assign out_valid = valid_q;
  assign match = match_q;
  assign miscount = mis_q;
endmodule
